// File: rtl/spmv_mem_req_arbiter.sv
// SpMV memory request arbiter: per-channel load FIFOs plus a store FIFO,
// merged into one registered memory request stream.
module spmv_req_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 32,
  parameter int AF    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         af,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0] cnt;
  logic [AW:0] free;
  logic full;
  logic wr_ok;

  assign full  = cnt == (AW+1)'(DEPTH);
  assign free  = (AW+1)'(DEPTH) - cnt;
  assign wr_ok = push && (!full || pop);
  assign ovf   = push && full && !pop;
  assign empty = cnt == '0;
  assign dout  = mem[rp];

  // storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= din;
  end

  // pointers, occupancy and the one-cycle-late almost-full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      af  <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop)   rp <= rp + 1'b1;
      unique case ({wr_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      af <= int'(free) <= AF;
    end
  end
endmodule

module spmv_mem_req_arbiter #(
  parameter int NUM_LD_CH  = 2,
  parameter int SUBTAG_W   = 2,
  parameter int FIFO_DEPTH = 32,
  parameter int AF_COUNT   = 8,
  parameter int RR_MODE    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_LD_CH-1:0]          ld_push,
  input  logic [48*NUM_LD_CH-1:0]       ld_addr,
  input  logic [SUBTAG_W*NUM_LD_CH-1:0] ld_subtag,
  output logic [NUM_LD_CH-1:0]          ld_almost_full,
  input  logic                          st_push,
  input  logic [63:0]                   st_data,
  output logic                          st_almost_full,
  input  logic                          cfg_load,
  input  logic [47:0]                   cfg_st_base,
  input  logic [47:0]                   cfg_st_end,
  output logic                          st_done,
  output logic                          ovf_err,
  output logic                          req_mem_ld,
  output logic                          req_mem_st,
  output logic [47:0]                   req_mem_addr,
  output logic [63:0]                   req_mem_d_or_tag,
  input  logic                          req_mem_stall
);
  localparam int LDW = 48 + SUBTAG_W;
  localparam int LW  = (NUM_LD_CH > 1) ? $clog2(NUM_LD_CH) : 1;

  logic [NUM_LD_CH-1:0] ld_empty;
  logic [NUM_LD_CH-1:0] ld_pop;
  logic [NUM_LD_CH-1:0] ld_ovf;
  logic [LDW-1:0] ld_head [NUM_LD_CH];
  logic [LDW-1:0] ld_pick;
  logic [63:0] ld_tag;
  logic [63:0] st_head;
  logic st_empty;
  logic st_ovf;
  logic gnt_ok;
  logic st_gnt;
  logic st_issue;
  logic ld_gnt;
  logic [LW-1:0] ld_sel;
  logic [LW-1:0] k_sel;
  logic [LW-1:0] rr_ptr;
  int idx;
  logic [47:0] st_ptr;
  logic [47:0] st_end;
  logic cfg_seen;

  for (genvar gi = 0; gi < NUM_LD_CH; gi++) begin : g_ld
    spmv_req_fifo #(
      .W(LDW), .DEPTH(FIFO_DEPTH), .AF(AF_COUNT)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (ld_push[gi]),
      .din  ({ld_subtag[gi*SUBTAG_W +: SUBTAG_W],
              ld_addr[gi*48 +: 48]}),
      .pop  (ld_pop[gi]),
      .dout (ld_head[gi]),
      .empty(ld_empty[gi]),
      .af   (ld_almost_full[gi]),
      .ovf  (ld_ovf[gi])
    );
  end

  spmv_req_fifo #(
    .W(64), .DEPTH(FIFO_DEPTH), .AF(AF_COUNT)
  ) u_st_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (st_push),
    .din  (st_data),
    .pop  (st_gnt),
    .dout (st_head),
    .empty(st_empty),
    .af   (st_almost_full),
    .ovf  (st_ovf)
  );

  assign gnt_ok   = enable && !req_mem_stall && !rst;
  assign st_issue = st_gnt && (st_ptr != st_end);
  assign ld_pick  = ld_head[ld_sel];
  assign ld_tag   = {{(61-SUBTAG_W){1'b0}},
                     ld_pick[LDW-1:48], 3'(ld_sel)};

  // grant: stores first, then fixed or rotating load search
  always_comb begin
    st_gnt = 1'b0;
    ld_gnt = 1'b0;
    ld_sel = '0;
    k_sel  = '0;
    idx    = 0;
    if (gnt_ok) begin
      if (!st_empty) begin
        st_gnt = 1'b1;
      end else begin
        for (int k = 0; k < NUM_LD_CH; k++) begin
          idx = (RR_MODE != 0) ? int'(rr_ptr) + 1 + k : k;
          if (idx >= NUM_LD_CH) idx = idx - NUM_LD_CH;
          k_sel = LW'(idx);
          if (!ld_gnt && !ld_empty[k_sel]) begin
            ld_gnt = 1'b1;
            ld_sel = k_sel;
          end
        end
      end
    end
    ld_pop = NUM_LD_CH'(ld_gnt) << ld_sel;
  end

  // request register, store window and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      req_mem_ld       <= 1'b0;
      req_mem_st       <= 1'b0;
      req_mem_addr     <= '0;
      req_mem_d_or_tag <= '0;
      st_ptr           <= '0;
      st_end           <= '0;
      cfg_seen         <= 1'b0;
      st_done          <= 1'b0;
      rr_ptr           <= LW'(NUM_LD_CH - 1);
    end else begin
      req_mem_ld <= ld_gnt;
      req_mem_st <= st_issue;
      if (ld_gnt) begin
        req_mem_addr     <= ld_pick[47:0];
        req_mem_d_or_tag <= ld_tag;
        rr_ptr           <= ld_sel;
      end else if (st_issue) begin
        req_mem_addr     <= st_ptr;
        req_mem_d_or_tag <= st_head;
      end
      if (cfg_load) begin
        st_ptr   <= cfg_st_base;
        st_end   <= cfg_st_end;
        cfg_seen <= 1'b1;
        st_done  <= 1'b0;
      end else begin
        if (st_issue) st_ptr <= st_ptr + 48'd8;
        st_done <= st_done || (cfg_seen && st_ptr == st_end);
      end
    end
  end

  // sticky overflow on any dropped push
  always_ff @(posedge clk) begin
    if (rst) ovf_err <= 1'b0;
    else     ovf_err <= ovf_err || st_ovf || (|ld_ovf);
  end
endmodule

// File: tb/tb_spmv_mem_req_arbiter.sv
// Bench: fixed-priority and round-robin arbiters side by side,
// compared every cycle against a queue-based request model.
module tb_spmv_mem_req_arbiter;
  localparam int NCH = 2;
  localparam int DEPTH = 32;
  localparam int AF = 8;

  logic clk = 1'b0;
  logic rst, enable, stall;
  logic [NCH-1:0] ld_push;
  logic [48*NCH-1:0] ld_addr;
  logic [2*NCH-1:0] ld_subtag;
  logic st_push, cfg_load;
  logic [63:0] st_data;
  logic [47:0] cfg_base, cfg_end;

  logic [NCH-1:0] laf [2];
  logic saf [2];
  logic sdn [2];
  logic ovf [2];
  logic rml [2];
  logic rms [2];
  logic [47:0] rma [2];
  logic [63:0] rmd [2];

  logic [63:0] q [6][$];
  int rr_last [2];
  logic [47:0] sp [2];
  logic [47:0] se [2];
  bit seen [2];
  bit done_m [2];
  bit ovf_m [2];
  bit e_ld [2];
  bit e_st [2];
  logic [47:0] e_addr [2];
  logic [63:0] e_dt [2];
  logic [NCH-1:0] e_laf [2];
  bit e_saf [2];

  logic [47:0] lg_a [2][$];
  logic [63:0] lg_d [2][$];
  bit lg_s [2][$];
  int lg_t [2][$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    spmv_mem_req_arbiter #(
      .NUM_LD_CH(NCH), .SUBTAG_W(2), .FIFO_DEPTH(DEPTH),
      .AF_COUNT(AF), .RR_MODE(m)
    ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .ld_push(ld_push), .ld_addr(ld_addr),
      .ld_subtag(ld_subtag), .ld_almost_full(laf[m]),
      .st_push(st_push), .st_data(st_data),
      .st_almost_full(saf[m]), .cfg_load(cfg_load),
      .cfg_st_base(cfg_base), .cfg_st_end(cfg_end),
      .st_done(sdn[m]), .ovf_err(ovf[m]),
      .req_mem_ld(rml[m]), .req_mem_st(rms[m]),
      .req_mem_addr(rma[m]), .req_mem_d_or_tag(rmd[m]),
      .req_mem_stall(stall)
    );
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance the model by one clock edge from the current inputs
  task automatic model_step(input int m);
    int b = m * 3;
    int pick;
    int c;
    bit nd;
    logic [63:0] e;
    if (rst) begin
      for (int i = 0; i < 3; i++) q[b+i].delete();
      rr_last[m] = NCH - 1;
      sp[m] = '0; se[m] = '0;
      seen[m] = 0; done_m[m] = 0; ovf_m[m] = 0;
      e_ld[m] = 0; e_st[m] = 0;
      e_addr[m] = '0; e_dt[m] = '0;
      e_laf[m] = '0; e_saf[m] = 0;
      return;
    end
    for (int i = 0; i < NCH; i++)
      e_laf[m][i] = (DEPTH - q[b+i].size()) <= AF;
    e_saf[m] = (DEPTH - q[b+2].size()) <= AF;
    nd = done_m[m] || (seen[m] && sp[m] == se[m]);
    e_ld[m] = 0;
    e_st[m] = 0;
    if (enable && !stall) begin
      if (q[b+2].size() > 0) begin
        e = q[b+2].pop_front();
        if (sp[m] != se[m]) begin
          e_st[m] = 1;
          e_addr[m] = sp[m];
          e_dt[m] = e;
          sp[m] = sp[m] + 48'd8;
        end
      end else begin
        pick = -1;
        for (int k = 0; k < NCH; k++) begin
          c = (m == 1) ? (rr_last[m] + 1 + k) % NCH : k;
          if (pick < 0 && q[b+c].size() > 0) pick = c;
        end
        if (pick >= 0) begin
          e = q[b+pick].pop_front();
          e_ld[m] = 1;
          e_addr[m] = e[47:0];
          e_dt[m] = (64'(e[49:48]) << 3) + 64'(pick);
          rr_last[m] = pick;
        end
      end
    end
    for (int i = 0; i < NCH; i++)
      if (ld_push[i]) begin
        if (q[b+i].size() < DEPTH)
          q[b+i].push_back({14'd0, ld_subtag[2*i +: 2],
                            ld_addr[48*i +: 48]});
        else ovf_m[m] = 1;
      end
    if (st_push) begin
      if (q[b+2].size() < DEPTH) q[b+2].push_back(st_data);
      else ovf_m[m] = 1;
    end
    if (cfg_load) begin
      sp[m] = cfg_base; se[m] = cfg_end;
      seen[m] = 1; done_m[m] = 0;
    end else begin
      done_m[m] = nd;
    end
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("ld%0d", m), 64'(rml[m]), 64'(e_ld[m]));
      chk($sformatf("st%0d", m), 64'(rms[m]), 64'(e_st[m]));
      chk($sformatf("addr%0d", m), 64'(rma[m]), 64'(e_addr[m]));
      chk($sformatf("dt%0d", m), rmd[m], e_dt[m]);
      chk($sformatf("laf%0d", m), 64'(laf[m]), 64'(e_laf[m]));
      chk($sformatf("saf%0d", m), 64'(saf[m]), 64'(e_saf[m]));
      chk($sformatf("done%0d", m), 64'(sdn[m]), 64'(done_m[m]));
      chk($sformatf("ovf%0d", m), 64'(ovf[m]), 64'(ovf_m[m]));
      if (rml[m] || rms[m]) begin
        lg_a[m].push_back(rma[m]);
        lg_d[m].push_back(rmd[m]);
        lg_s[m].push_back(rms[m]);
        lg_t[m].push_back(cyc);
      end
    end
  endtask

  task automatic clr();
    rst = 0; ld_push = '0; st_push = 0; cfg_load = 0;
  endtask

  task automatic do_rst();
    clr(); rst = 1; enable = 1; stall = 0;
    step(); step();
    clr();
    for (int m = 0; m < 2; m++) begin
      lg_a[m].delete(); lg_d[m].delete();
      lg_s[m].delete(); lg_t[m].delete();
    end
  endtask

  task automatic cfg(input logic [47:0] b, input logic [47:0] e);
    cfg_load = 1; cfg_base = b; cfg_end = e;
    step(); clr();
  endtask

  task automatic rnd_ld();
    ld_addr = {48'($urandom) ^ {$urandom, 16'h0},
               48'($urandom) ^ {$urandom, 16'h0}};
    ld_subtag = 4'($urandom);
  endtask

  int tdrop;
  int exp_ch0 [4] = '{0, 0, 1, 1};
  int exp_ch1 [4] = '{0, 1, 0, 1};

  initial begin
    clr(); enable = 1; stall = 0;
    ld_addr = '0; ld_subtag = '0; st_data = '0;
    cfg_base = '0; cfg_end = '0;
    do_rst();
    chk("rst_done", 64'(sdn[0]), 64'd0);

    // store window: two stores issue, third discarded
    cfg(48'h1000, 48'h1010);
    for (int i = 0; i < 3; i++) begin
      st_push = 1; st_data = 64'hD0 + 64'(i);
      step();
    end
    clr();
    repeat (6) step();
    chk("s_cnt", 64'(lg_a[0].size()), 64'd2);
    if (lg_a[0].size() == 2) begin
      chk("s_a0", 64'(lg_a[0][0]), 64'h1000);
      chk("s_d0", lg_d[0][0], 64'hD0);
      chk("s_a1", 64'(lg_a[0][1]), 64'h1008);
      chk("s_d1", lg_d[0][1], 64'hD1);
    end
    chk("s_done", 64'(sdn[0]), 64'd1);

    // fixed vs round-robin load order
    do_rst();
    enable = 0;
    for (int i = 0; i < 2; i++) begin
      ld_push = 2'b11; rnd_ld(); step();
    end
    clr(); enable = 1;
    repeat (6) step();
    chk("o_cnt0", 64'(lg_d[0].size()), 64'd4);
    chk("o_cnt1", 64'(lg_d[1].size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (lg_d[0].size() > i)
        chk($sformatf("fix%0d", i), 64'(lg_d[0][i][2:0]),
            64'(exp_ch0[i]));
      if (lg_d[1].size() > i)
        chk($sformatf("rr%0d", i), 64'(lg_d[1][i][2:0]),
            64'(exp_ch1[i]));
    end

    // store beats a same-cycle load
    do_rst();
    cfg(48'h40, 48'h80);
    st_push = 1; st_data = 64'hABCD; ld_push = 2'b01; rnd_ld();
    step(); clr();
    repeat (4) step();
    chk("p_cnt", 64'(lg_s[0].size()), 64'd2);
    if (lg_s[0].size() == 2) begin
      chk("p_first", 64'(lg_s[0][0]), 64'd1);
      chk("p_second", 64'(lg_s[0][1]), 64'd0);
      chk("p_gap", 64'(lg_t[0][1] - lg_t[0][0]), 64'd1);
    end

    // stall holds everything, nothing lost
    do_rst();
    cfg(48'h2000, 48'h2100);
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      st_push = 1; st_data = {$urandom, $urandom};
      ld_push = 2'b11; rnd_ld(); step();
    end
    clr();
    repeat (5) step();
    chk("h_none", 64'(lg_a[0].size()), 64'd0);
    stall = 0; tdrop = cyc + 1;
    repeat (15) step();
    chk("h_cnt", 64'(lg_a[0].size()), 64'd12);
    if (lg_t[0].size() > 0)
      chk("h_first", 64'(lg_t[0][0]), 64'(tdrop));

    // overflow on ch0
    do_rst();
    enable = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      ld_push = 2'b01; rnd_ld(); step();
    end
    clr();
    repeat (2) step();
    chk("v_ovf", 64'(ovf[0]), 64'd1);
    chk("v_af", 64'(laf[0][0]), 64'd1);
    enable = 1;
    repeat (40) step();
    chk("v_cnt", 64'(lg_a[0].size()), 64'(DEPTH));

    // random traffic
    do_rst();
    for (int n = 0; n < 3000; n++) begin
      clr();
      rst = $urandom_range(0, 299) == 0;
      enable = $urandom_range(0, 9) != 0;
      stall = $urandom_range(0, 3) == 0;
      for (int i = 0; i < NCH; i++)
        ld_push[i] = $urandom_range(0, 2) == 0;
      rnd_ld();
      st_push = $urandom_range(0, 3) == 0;
      st_data = {$urandom, $urandom};
      cfg_load = $urandom_range(0, 39) == 0;
      cfg_base = {16'($urandom), 29'($urandom), 3'b000};
      cfg_end = cfg_base + 48'(8 * $urandom_range(0, 8));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spmv_mem_req_arbiter.md
SPMV_MEM_REQ_ARBITER -- requirements
Module: spmv_mem_req_arbiter

Interface
REQ-001 Parameter NUM_LD_CH, default 2, number of load request channels (1..8).
REQ-002 Parameter SUBTAG_W, default 2, per-channel tag bits carried with each load.
REQ-003 Parameter FIFO_DEPTH, default 32, entries per channel FIFO (power of 2, >=4).
REQ-004 Parameter AF_COUNT, default 8, free-entry threshold at which almost-full asserts.
REQ-005 Parameter RR_MODE, default 0; 0 = fixed load priority, 1 = round-robin load priority.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 enable  in  1  issue gate; 0 blocks all grants.
REQ-009 ld_push  in  NUM_LD_CH  per-channel load push.
REQ-010 ld_addr  in  48*NUM_LD_CH  load byte addresses, channel i at bits [48i+47:48i].
REQ-011 ld_subtag  in  SUBTAG_W*NUM_LD_CH  per-channel subtag.
REQ-012 ld_almost_full  out  NUM_LD_CH  registered per-channel almost-full.
REQ-013 st_push  in  1  store data push.
REQ-014 st_data  in  64  store data.
REQ-015 st_almost_full  out  1  registered store-FIFO almost-full.
REQ-016 cfg_load  in  1  loads store window.
REQ-017 cfg_st_base  in  48  first store address.
REQ-018 cfg_st_end  in  48  store end address (exclusive).
REQ-019 st_done  out  1  sticky: store pointer reached end.
REQ-020 ovf_err  out  1  sticky: push to a full FIFO.
REQ-021 req_mem_ld, req_mem_st  out  1 each  registered memory request strobes.
REQ-022 req_mem_addr  out  48  request address.
REQ-023 req_mem_d_or_tag  out  64  store data or load tag.
REQ-024 req_mem_stall  in  1  memory back-pressure.

Function
REQ-025 One FIFO per load channel (width 48+SUBTAG_W) and one store FIFO (width 64), each FIFO_DEPTH deep.
REQ-026 Push to a full FIFO is dropped and sets ovf_err; push and pop same cycle on a full FIFO is accepted.
REQ-027 *_almost_full registered: asserts cycle after free entries <= AF_COUNT.
REQ-028 Grant evaluated combinationally each cycle; no grant when req_mem_stall=1, enable=0, or rst=1.
REQ-029 Store FIFO non-empty has absolute priority over all load channels.
REQ-030 RR_MODE=0: lowest-index non-empty load channel wins.
REQ-031 RR_MODE=1: search starts at (last granted load channel + 1) mod NUM_LD_CH; pointer updates only on load grant; reset value NUM_LD_CH-1.
REQ-032 Granted FIFO popped in grant cycle; request presented on outputs exactly one cycle later (single register stage); at most one request per cycle.
REQ-033 Load request: req_mem_ld=1, addr = FIFO addr, d_or_tag[2:0] = channel index, d_or_tag[3+SUBTAG_W-1:3] = subtag, remaining bits 0.
REQ-034 Store request: req_mem_st=1, addr = st_ptr, d_or_tag = data; st_ptr += 8 (48-bit wrap) on each issued store.
REQ-035 Store popped while st_ptr == cfg_st_end: entry discarded, req_mem_st stays 0, st_ptr unchanged.
REQ-036 st_done sets the cycle after st_ptr becomes equal to cfg_st_end; cleared only by cfg_load or rst.
REQ-037 cfg_load: st_ptr<=cfg_st_base, end register<=cfg_st_end, st_done<=0; wins over a coincident store increment.
REQ-038 Strobes 0 in any cycle without a preceding grant; addr/data hold last values.

Reset
REQ-039 rst: all FIFOs empty, st_ptr=0, end=0, RR pointer=NUM_LD_CH-1, all outputs 0 next cycle.
REQ-040 rst mid-operation: pending grant's request suppressed; in-flight FIFO contents lost.

Verification
REQ-041 cfg_load base=0x1000 end=0x1010, push 3 stores D0..D2 -> st at 0x1000 (D0), 0x1008 (D1); D2 dropped; st_done=1.
REQ-042 RR_MODE=0, ch0 and ch1 each hold 2 loads -> order ch0,ch0,ch1,ch1, tags 0,0,1,1.
REQ-043 RR_MODE=1, same stimulus -> order ch0,ch1,ch0,ch1.
REQ-044 Store and ch0 load pushed same cycle -> store issued first; load one cycle later.
REQ-045 req_mem_stall held 5 cycles with full queues -> zero strobes; first request one cycle after stall drops; no entry lost.
REQ-046 Fill ch0 to FIFO_DEPTH then push once more -> ovf_err=1, ld_almost_full[0]=1, exactly FIFO_DEPTH loads later issued.
